// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg
// Shared types and defaults for the fetch stage of the pipelined ARMv8 core.
// Revision: 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int INSN_W = 32;
  localparam int ADDR_W = 64;

  localparam logic [INSN_W-1:0] NOP_INSN_DEFAULT = 32'hD503201F;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 64'h0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // Sequential successor; wraps modulo 2^64.
  function automatic logic [ADDR_W-1:0] next_seq_pc(input logic [ADDR_W-1:0] pc);
    return pc + 64'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// instruction_fetch_if
// Instruction-memory request/acknowledge bus.
// Revision: 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
  import core_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INSN_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface
`default_nettype wire

// File: rtl/pc_register.sv
`default_nettype none
// ============================================================================
// pc_register
// Async-reset register with load enable, used for the program counter.
// Revision: 1.0 - initial release
// ============================================================================
module pc_register #(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  // Capture the new value only when load is asserted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= RESET_VALUE;
    else if (load) q <= d;
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// instruction_fetch
// Fetch stage: PC sequencing, imem req/ack handshake, one-entry skid buffer
// for stalls, branch redirect with in-flight response discard, IF/ID register.
// Revision: 1.0 - initial release
// ============================================================================
module instruction_fetch
  import core_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [INSN_W-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic              stall,
  input  wire logic              redirect,
  input  wire logic [ADDR_W-1:0] redirect_pc,
  instruction_fetch_if.master    imem,
  output logic      [INSN_W-1:0] instruction,
  output logic      [ADDR_W-1:0] PC_out_IF_ID,
  output logic                   if_valid
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              pc_load;

  // Address of a request that must stay on the bus after a redirect.
  logic [ADDR_W-1:0] drain_addr;
  logic              drain_load;

  // Skid occupancy is implied by the HOLD state.
  logic [INSN_W-1:0] skid_insn;
  logic [ADDR_W-1:0] skid_pc;
  logic              skid_load;

  logic              ifid_load;
  logic [INSN_W-1:0] ifid_insn_n;
  logic [ADDR_W-1:0] ifid_pc_n;
  logic              ifid_valid_n;

  logic              ack;

  assign ack            = imem.imem_ack;
  assign imem.imem_req  = !reset && (state != HOLD);
  assign imem.imem_addr = (state == DRAIN) ? drain_addr : pc;

  pc_register #(
    .WIDTH       (ADDR_W),
    .RESET_VALUE (RESET_PC)
  ) u_pc_register (
    .clock (clock),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_next),
    .q     (pc)
  );

  // Fetch state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FETCH;
    else state <= state_next;
  end

  // Next state, PC update and IF/ID/skid load decisions; redirect beats stall.
  always_comb begin
    state_next   = state;
    pc_load      = 1'b0;
    pc_next      = next_seq_pc(pc);
    drain_load   = 1'b0;
    skid_load    = 1'b0;
    ifid_load    = 1'b0;
    ifid_insn_n  = instruction;
    ifid_pc_n    = PC_out_IF_ID;
    ifid_valid_n = if_valid;
    if (redirect) begin
      pc_load      = 1'b1;
      pc_next      = {redirect_pc[ADDR_W-1:2], 2'b00};
      ifid_load    = 1'b1;
      ifid_insn_n  = NOP_INSN;
      ifid_valid_n = 1'b0;
      case (state)
        FETCH: if (!ack) begin
          state_next = DRAIN;
          drain_load = 1'b1;
        end
        DRAIN:   if (ack) state_next = FETCH;
        default: state_next = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (ack) begin
            pc_load = 1'b1;
            if (!stall) begin
              ifid_load    = 1'b1;
              ifid_insn_n  = imem.imem_rdata;
              ifid_pc_n    = pc;
              ifid_valid_n = 1'b1;
            end else begin
              skid_load  = 1'b1;
              state_next = HOLD;
            end
          end else if (!stall) begin
            ifid_load    = 1'b1;
            ifid_insn_n  = NOP_INSN;
            ifid_valid_n = 1'b0;
          end
        end
        DRAIN: begin
          if (ack) state_next = FETCH;
          if (!stall) begin
            ifid_load    = 1'b1;
            ifid_insn_n  = NOP_INSN;
            ifid_valid_n = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_load    = 1'b1;
            ifid_insn_n  = skid_insn;
            ifid_pc_n    = skid_pc;
            ifid_valid_n = 1'b1;
            state_next   = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  // Remember the outstanding address when a redirect lands mid-request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) drain_addr <= '0;
    else if (drain_load) drain_addr <= pc;
  end

  // Skid buffer catches a response that arrives while decode is stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skid_insn <= '0;
      skid_pc   <= '0;
    end else if (skid_load) begin
      skid_insn <= imem.imem_rdata;
      skid_pc   <= pc;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instruction  <= NOP_INSN;
      PC_out_IF_ID <= '0;
      if_valid     <= 1'b0;
    end else if (ifid_load) begin
      instruction  <= ifid_insn_n;
      PC_out_IF_ID <= ifid_pc_n;
      if_valid     <= ifid_valid_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// tb_instruction_fetch
// Self-checking bench: scoreboard of expected IF/ID PCs against the stream
// decode consumes, plus directed checks around stall, redirect and reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] NOP = core_pkg::NOP_INSN_DEFAULT;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] instruction;
  logic [63:0] PC_out_IF_ID;
  logic        if_valid;

  logic        zero;
  logic [63:0] zero64;
  logic [31:0] instruction2;
  logic [63:0] pc2;
  logic        if_valid2;

  int          n_checks;
  int          n_errors;
  int          wait_states;
  int          wcnt;
  logic [63:0] sb[$];
  logic [63:0] mon_exp;
  logic        prev_pending;
  logic [63:0] prev_addr;

  instruction_fetch_if bus();
  instruction_fetch_if bus2();

  instruction_fetch dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem         (bus),
    .instruction  (instruction),
    .PC_out_IF_ID (PC_out_IF_ID),
    .if_valid     (if_valid)
  );

  instruction_fetch #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clock        (clock),
    .reset        (reset),
    .stall        (zero),
    .redirect     (zero),
    .redirect_pc  (zero64),
    .imem         (bus2),
    .instruction  (instruction2),
    .PC_out_IF_ID (pc2),
    .if_valid     (if_valid2)
  );

  assign zero   = 1'b0;
  assign zero64 = 64'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory returning addr[31:0] after wait_states cycles of wait.
  assign bus.imem_ack   = bus.imem_req && (wcnt == wait_states);
  assign bus.imem_rdata = bus.imem_addr[31:0];
  assign bus2.imem_ack   = bus2.imem_req;
  assign bus2.imem_rdata = bus2.imem_addr[31:0];

  always @(posedge clock or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (bus.imem_req) wcnt <= bus.imem_ack ? 0 : wcnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #1;
      if (sb.size() == 0) break;
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  // Decode consumes IF/ID when valid and not stalled; also watch addr stability.
  always @(negedge clock) begin
    if (!reset) begin
      if (prev_pending && bus.imem_req) check("addr_stable", bus.imem_addr, prev_addr);
      if (if_valid && !stall) begin
        if (sb.size() == 0) begin
          check("sb_extra", 64'(if_valid), 64'd0);
        end else begin
          mon_exp = sb.pop_front();
          check("ifid_pc", PC_out_IF_ID, mon_exp);
          check("ifid_insn", 64'(instruction), 64'(mon_exp[31:0]));
        end
      end
    end
    prev_pending <= !reset && bus.imem_req && !bus.imem_ack;
    prev_addr    <= bus.imem_addr;
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 64'd0;
    wait_states = 0;
    repeat (2) cyc();
    check("rst_valid", 64'(if_valid), 64'd0);
    check("rst_insn", 64'(instruction), 64'(NOP));
    check("rst_pc", PC_out_IF_ID, 64'd0);
    check("rst_req", 64'(bus.imem_req), 64'd0);

    // Zero-wait stream, stall at PC 8, redirect while fetching 0x20.
    for (int a = 0; a <= 'h1C; a += 4) sb.push_back(64'(a));
    for (int a = 'h100; a <= 'h108; a += 4) sb.push_back(64'(a));
    reset = 1'b0;
    #1;
    check("rel_addr", bus.imem_addr, 64'd0);
    check("rel_req", 64'(bus.imem_req), 64'd1);
    for (int i = 0; i < 20 && !(if_valid && PC_out_IF_ID == 64'd8); i++) cyc();
    check("reach_pc8", 64'(if_valid && PC_out_IF_ID == 64'd8), 64'd1);
    stall = 1'b1;
    check("stall_fetch12", bus.imem_addr, 64'd12);
    cyc();
    check("stall_req_off1", 64'(bus.imem_req), 64'd0);
    check("stall_hold_pc1", PC_out_IF_ID, 64'd8);
    cyc();
    check("stall_req_off2", 64'(bus.imem_req), 64'd0);
    check("stall_hold_pc2", PC_out_IF_ID, 64'd8);
    check("stall_hold_v", 64'(if_valid), 64'd1);
    cyc();
    stall = 1'b0;
    for (int i = 0; i < 40 && bus.imem_addr != 64'h20; i++) cyc();
    check("reach_0x20", bus.imem_addr, 64'h20);
    redirect = 1'b1;
    redirect_pc = 64'h103;
    cyc();
    redirect = 1'b0;
    check("redir_bubble_v", 64'(if_valid), 64'd0);
    check("redir_bubble_i", 64'(instruction), 64'(NOP));
    check("redir_addr", bus.imem_addr, 64'h100);
    wait_drain();
    reset = 1'b1;
    #1;
    check("rst2_req", 64'(bus.imem_req), 64'd0);
    check("rst2_valid", 64'(if_valid), 64'd0);

    // Two wait states, redirect one cycle into the 0x40 request.
    wait_states = 2;
    for (int a = 0; a <= 'h3C; a += 4) sb.push_back(64'(a));
    sb.push_back(64'h200);
    sb.push_back(64'h204);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 200 && bus.imem_addr != 64'h40; i++) cyc();
    check("reach_0x40", bus.imem_addr, 64'h40);
    cyc();
    redirect = 1'b1;
    redirect_pc = 64'h200;
    check("w2_addr_hold1", bus.imem_addr, 64'h40);
    cyc();
    redirect = 1'b0;
    check("w2_addr_hold2", bus.imem_addr, 64'h40);
    check("w2_req_hold", 64'(bus.imem_req), 64'd1);
    cyc();
    check("w2_new_addr", bus.imem_addr, 64'h200);
    wait_drain();

    // Redirect mid-request, then reset while draining.
    cyc();
    check("pre_drain_addr", bus.imem_addr, 64'h208);
    redirect = 1'b1;
    redirect_pc = 64'h300;
    cyc();
    redirect = 1'b0;
    check("drain_addr", bus.imem_addr, 64'h208);
    check("drain_bubble", 64'(if_valid), 64'd0);
    reset = 1'b1;
    #1;
    check("rst_drain_req", 64'(bus.imem_req), 64'd0);
    check("rst_drain_valid", 64'(if_valid), 64'd0);
    check("rst_drain_insn", 64'(instruction), 64'(NOP));

    wait_states = 0;
    for (int a = 0; a <= 8; a += 4) sb.push_back(64'(a));
    cyc();
    reset = 1'b0;
    #1;
    check("rel2_addr", bus.imem_addr, 64'd0);
    check("rel2_req", 64'(bus.imem_req), 64'd1);
    wait_drain();
    reset = 1'b1;
    #1;

    // Wrap-around of the reset PC on the second instance.
    sb.push_back(64'd0);
    sb.push_back(64'd4);
    cyc();
    reset = 1'b0;
    #1;
    check("wrap_addr", bus2.imem_addr, WRAP_PC);
    check("wrap_req", 64'(bus2.imem_req), 64'd1);
    cyc();
    check("wrap_pc0", pc2, WRAP_PC);
    check("wrap_v0", 64'(if_valid2), 64'd1);
    check("wrap_i0", 64'(instruction2), 64'(WRAP_PC[31:0]));
    cyc();
    check("wrap_pc1", pc2, 64'd0);
    check("wrap_v1", 64'(if_valid2), 64'd1);
    check("wrap_i1", 64'(instruction2), 64'd0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
